// File: rtl/framebuffer_scanout_pkg.sv
// Frame geometry and pixel types shared by the sys_clk framebuffer writer and the scanout reader,
// so both sides agree on the source frame size.
package framebuffer_scanout_pkg;

    localparam int FB_SRC_WIDTH  = 512;
    localparam int FB_SRC_HEIGHT = 384;

    typedef logic [11:0] color12;

endpackage

// File: rtl/framebuffer_scanout_line_buffer_ram.sv
// Ping-pong line buffer: simple dual-port RAM with one write port and one registered read port.
// Contents are deliberately not reset; stale rows are acceptable until they are refetched.
module line_buffer_ram
    import framebuffer_scanout_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  color12            wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output color12            rd_data
);

    color12 mem_q [2**ADDR_W];
    color12 rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer scanout: prefetches one source row per display line pair into a ping-pong line buffer
// and replays it 2x2-scaled. Optional test pattern selected by macro SCANOUT_TEST_PATTERN_EN.
//
//   state | meaning
//   IDLE  | waiting for a fetch trigger at hcount 0
//   FETCH | issuing one BRAM read address per cycle for the current row
//   DRAIN | waiting for the last BRAM_LATENCY reads to land in the line buffer
module framebuffer_scanout
    import framebuffer_scanout_pkg::*;
#(
    parameter int SRC_WIDTH    = FB_SRC_WIDTH,
    parameter int SRC_HEIGHT   = FB_SRC_HEIGHT,
    parameter int ADDR_BITS    = 18,
    parameter int COORD_BITS   = 16,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [COORD_BITS-1:0] hcount_in,
    input  logic [COORD_BITS-1:0] vcount_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  blank_in,
    input  logic                  test_pattern_in,
    output logic [ADDR_BITS-1:0]  pix_addr_out,
    input  logic [15:0]           pix_data_in,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  underrun_out
);

    localparam int COL_BITS   = $clog2(SRC_WIDTH);
    localparam int LB_BITS    = COL_BITS + 1;
    localparam int DRAIN_BITS = $clog2(BRAM_LATENCY + 1);

    localparam logic [COORD_BITS-1:0] VBLANK_LINE = COORD_BITS'(2 * SRC_HEIGHT);
    localparam logic [COORD_BITS-1:0] ROW_LIMIT   = COORD_BITS'(2 * SRC_HEIGHT - 2);
    localparam logic [ADDR_BITS-1:0]  ROW_STRIDE  = ADDR_BITS'(SRC_WIDTH);
    localparam logic [COL_BITS-1:0]   COL_LAST    = COL_BITS'(SRC_WIDTH - 1);
    localparam logic [DRAIN_BITS-1:0] DRAIN_INIT  = DRAIN_BITS'(BRAM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } scanout_state_t;

    scanout_state_t        state_q, state_d;
    logic [COL_BITS-1:0]   col_q, col_d;
    logic                  bank_q, bank_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [DRAIN_BITS-1:0] drain_q, drain_d;

    logic [BRAM_LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [LB_BITS-1:0]      tag_sr_q [BRAM_LATENCY];
    logic [LB_BITS-1:0]      tag_sr_d [BRAM_LATENCY];

    logic                 trig_vblank, trig_row, trig;
    logic [ADDR_BITS-1:0] trig_row_idx;

    // Fetch triggers; row N+1 is fetched during the first line of row N so it is ready two lines later.
    always_comb begin
        trig_vblank  = (hcount_in == '0) && (vcount_in == VBLANK_LINE);
        trig_row     = (hcount_in == '0) && !vcount_in[0] && (vcount_in < ROW_LIMIT);
        trig         = trig_vblank || trig_row;
        trig_row_idx = trig_vblank ? '0
                                   : ADDR_BITS'(vcount_in >> 1) + ADDR_BITS'(1);
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        bank_d       = bank_q;
        addr_d       = addr_q;
        drain_d      = drain_q;
        underrun_out = trig && (state_q != IDLE);
        vld_sr_d     = {vld_sr_q[BRAM_LATENCY-2:0], 1'b0};

        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = FETCH;
                    col_d   = '0;
                    bank_d  = trig_row_idx[0];
                    addr_d  = trig_row_idx * ROW_STRIDE;
                end
            end
            FETCH: begin
                vld_sr_d[0] = 1'b1;
                if (col_q == COL_LAST) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_INIT;
                end else begin
                    col_d  = col_q + COL_BITS'(1);
                    addr_d = addr_q + ADDR_BITS'(1);
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - DRAIN_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        tag_sr_d[0] = {bank_q, col_q};
        for (int i = 1; i < BRAM_LATENCY; i++) begin
            tag_sr_d[i] = tag_sr_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            col_q    <= '0;
            bank_q   <= 1'b0;
            addr_q   <= '0;
            drain_q  <= '0;
            vld_sr_q <= '0;
            for (int i = 0; i < BRAM_LATENCY; i++) begin
                tag_sr_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            bank_q   <= bank_d;
            addr_q   <= addr_d;
            drain_q  <= drain_d;
            vld_sr_q <= vld_sr_d;
            for (int i = 0; i < BRAM_LATENCY; i++) begin
                tag_sr_q[i] <= tag_sr_d[i];
            end
        end
    end

    assign pix_addr_out = addr_q;

    // Display read: hcount>>1 wraps inside the bank during blanking, which is harmless since it is masked.
    logic [LB_BITS-1:0] lb_rd_addr;
    color12             lb_rd_data;

    assign lb_rd_addr = {vcount_in[1], hcount_in[COL_BITS:1]};

    line_buffer_ram #(
        .ADDR_W (LB_BITS)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (vld_sr_q[BRAM_LATENCY-1]),
        .wr_addr (tag_sr_q[BRAM_LATENCY-1]),
        .wr_data (pix_data_in[11:0]),
        .rd_addr (lb_rd_addr),
        .rd_data (lb_rd_data)
    );

    logic   blank_d1_q, blank_d1_d;
    logic   hsync_d1_q, hsync_d1_d;
    logic   vsync_d1_q, vsync_d1_d;
    logic   vga_hs_q, vga_hs_d;
    logic   vga_vs_q, vga_vs_d;
    color12 color_q, color_d;
    color12 color_src;

`ifdef SCANOUT_TEST_PATTERN_EN
    logic       tp_d1_q, tp_d1_d;
    logic [3:0] hpat_q, hpat_d;
    logic [3:0] vpat_q, vpat_d;

    always_comb begin
        tp_d1_d   = test_pattern_in;
        hpat_d    = hcount_in[9:6];
        vpat_d    = vcount_in[9:6];
        color_src = tp_d1_q ? {hpat_q, vpat_q, hpat_q ^ vpat_q} : lb_rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_d1_q <= 1'b0;
            hpat_q  <= '0;
            vpat_q  <= '0;
        end else begin
            tp_d1_q <= tp_d1_d;
            hpat_q  <= hpat_d;
            vpat_q  <= vpat_d;
        end
    end
`else
    logic unused_test_pattern;
    assign unused_test_pattern = test_pattern_in;
    assign color_src           = lb_rd_data;
`endif

    logic unused_pix_bits;
    assign unused_pix_bits = &{1'b0, pix_data_in[15:12]};

    always_comb begin
        blank_d1_d = blank_in;
        hsync_d1_d = hsync_in;
        vsync_d1_d = vsync_in;
        vga_hs_d   = ~hsync_d1_q;
        vga_vs_d   = ~vsync_d1_q;
        color_d    = blank_d1_q ? '0 : color_src;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_d1_q <= 1'b0;
            hsync_d1_q <= 1'b0;
            vsync_d1_q <= 1'b0;
            vga_hs_q   <= 1'b1;
            vga_vs_q   <= 1'b1;
            color_q    <= '0;
        end else begin
            blank_d1_q <= blank_d1_d;
            hsync_d1_q <= hsync_d1_d;
            vsync_d1_q <= vsync_d1_d;
            vga_hs_q   <= vga_hs_d;
            vga_vs_q   <= vga_vs_d;
            color_q    <= color_d;
        end
    end

    assign vga_r  = color_q[11:8];
    assign vga_g  = color_q[7:4];
    assign vga_b  = color_q[3:0];
    assign vga_hs = vga_hs_q;
    assign vga_vs = vga_vs_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench for framebuffer_scanout: BRAM model returns addr[11:0] after two cycles;
// expected addresses and pixels are queued at stimulus time and popped when due.
module tb_framebuffer_scanout;

    localparam int W    = 512;
    localparam int AB   = 18;
    localparam int CB   = 16;
    localparam int LAT  = 2;
    localparam int LINE = 1100;

`ifdef SCANOUT_TEST_PATTERN_EN
    localparam bit TP_EN = 1'b1;
`else
    localparam bit TP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CB-1:0] hcount_in, vcount_in;
    logic          hsync_in, vsync_in, blank_in, test_pattern_in;
    logic [AB-1:0] pix_addr_out;
    logic [15:0]   pix_data_in;
    logic [3:0]    vga_r, vga_g, vga_b;
    logic          vga_hs, vga_vs, underrun_out;

    framebuffer_scanout dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .hsync_in        (hsync_in),
        .vsync_in        (vsync_in),
        .blank_in        (blank_in),
        .test_pattern_in (test_pattern_in),
        .pix_addr_out    (pix_addr_out),
        .pix_data_in     (pix_data_in),
        .vga_r           (vga_r),
        .vga_g           (vga_g),
        .vga_b           (vga_b),
        .vga_hs          (vga_hs),
        .vga_vs          (vga_vs),
        .underrun_out    (underrun_out)
    );

    always #5 clk = ~clk;

    logic [AB-1:0] bram_a_q [LAT];
    always @(posedge clk) begin
        bram_a_q[0] <= pix_addr_out;
        for (int i = 1; i < LAT; i++) bram_a_q[i] <= bram_a_q[i-1];
    end
    assign pix_data_in = {4'h0, bram_a_q[LAT-1][11:0]};

    typedef struct {
        int          due;
        logic [11:0] rgb;
        bit          chk_rgb;
        logic        hs;
        logic        vs;
    } pix_exp_t;

    typedef struct {
        int          due;
        logic [AB-1:0] addr;
    } addr_exp_t;

    pix_exp_t  pix_q[$];
    addr_exp_t addr_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fetch_start = -10000;
    int bank_row [2] = '{-1, -1};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
    endtask

    task automatic drive_cycle(input int h, input int v, input bit tp);
        bit          trig, busy, blank, hs, vs;
        int          row, b;
        pix_exp_t    e;
        addr_exp_t   a;
        logic [9:0]  hb, vb;
        tick();
        #1;
        blank = (h >= 1024) || (v >= 768);
        hs    = (h >= 1048) && (h < 1090);
        vs    = (v >= 771) && (v < 777);
        hcount_in       = CB'(h);
        vcount_in       = CB'(v);
        blank_in        = blank;
        hsync_in        = hs;
        vsync_in        = vs;
        test_pattern_in = tp;

        trig = (h == 0) && ((v == 768) || ((v % 2 == 0) && (v < 766)));
        busy = (cyc >= fetch_start + 1) && (cyc <= fetch_start + 514);
        if (trig && !busy) begin
            row = (v == 768) ? 0 : (v >> 1) + 1;
            for (int k = 0; k < W; k++) begin
                a.due  = cyc + 1 + k;
                a.addr = AB'(row * W + k);
                addr_q.push_back(a);
            end
            fetch_start = cyc;
            bank_row[row & 1] = row;
        end

        hb = 10'(h);
        vb = 10'(v);
        b  = (v >> 1) & 1;
        e.due     = cyc + 2;
        e.hs      = ~hs;
        e.vs      = ~vs;
        e.chk_rgb = 1'b1;
        if (blank) e.rgb = 12'h000;
        else if (TP_EN && tp) e.rgb = {hb[9:6], vb[9:6], hb[9:6] ^ vb[9:6]};
        else if (bank_row[b] >= 0) e.rgb = 12'((bank_row[b] * W + (h >> 1)) & 12'hFFF);
        else begin
            e.rgb     = 12'h000;
            e.chk_rgb = 1'b0;
        end
        pix_q.push_back(e);

        @(negedge clk);
        check_eq("underrun", 32'(underrun_out), 32'(trig && busy));
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            a = addr_q.pop_front();
            check_eq("pix_addr", 32'(pix_addr_out), 32'(a.addr));
        end
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            e = pix_q.pop_front();
            if (e.chk_rgb) check_eq("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
            check_eq("vga_hs", 32'(vga_hs), 32'(e.hs));
            check_eq("vga_vs", 32'(vga_vs), 32'(e.vs));
        end
    endtask

    task automatic run_line(input int v, input bit tp);
        for (int h = 0; h < LINE; h++) drive_cycle(h, v, tp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_addr"}, 32'(pix_addr_out), 32'h0);
        check_eq({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'h0);
        check_eq({tag, "_hs"}, 32'(vga_hs), 32'h1);
        check_eq({tag, "_vs"}, 32'(vga_vs), 32'h1);
        check_eq({tag, "_underrun"}, 32'(underrun_out), 32'h0);
    endtask

    initial begin
        rst_n           = 1'b0;
        hcount_in       = CB'(1);
        vcount_in       = CB'(800);
        hsync_in        = 1'b0;
        vsync_in        = 1'b0;
        blank_in        = 1'b1;
        test_pattern_in = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_line(768, 1'b0);   // vblank: row 0 into bank 0
        run_line(8, 1'b0);     // shows stale row 0 from bank 0, fetches row 5 into bank 1
        run_line(10, 1'b0);    // shows row 5, fetches row 6 into bank 0
        run_line(11, 1'b1);    // row 5 again; test_pattern_in only matters with the macro
        run_line(12, 1'b0);    // shows row 6, fetches row 7 into bank 1

        // A second trigger 100 cycles into the row-8 fetch must be ignored and flagged.
        for (int h = 0; h < LINE; h++) drive_cycle((h == 100) ? 0 : h, 14, 1'b0);

        // Asynchronous reset while the row-9 fetch is at column 200.
        for (int h = 0; h <= 201; h++) drive_cycle(h, 16, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        pix_q.delete();
        addr_q.delete();
        fetch_start = -10000;
        bank_row[1] = -1;
        hcount_in   = CB'(1);
        vcount_in   = CB'(800);
        blank_in    = 1'b1;
        hsync_in    = 1'b0;
        vsync_in    = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_reset_outputs("midreset_hold");
        rst_n = 1'b1;

        run_line(18, 1'b0);    // restarts at row 10 column 0

        for (int h = 60; h < 80; h++) drive_cycle(h, 128, 1'b1);
        for (int h = 1020; h < 1040; h++) drive_cycle(h, 128, 1'b1);
        for (int h = 1040; h < 1100; h++) drive_cycle(h, 771, 1'b0);
        for (int h = 1; h < 8; h++) drive_cycle(h, 800, 1'b0);

        check_eq("addr_q_drained", 32'(addr_q.size()), 32'h0);
        check_eq("pix_q_drained", 32'(pix_q.size() > 2), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
